// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared defaults and types for the hazard scoreboard.
//   NREG_DEF / AW_DEF / LATW_DEF / NRD_DEF / WB_LAT_DEF : parameter defaults
//   LAT_ALU / LAT_LOAD : latency encodings driven on wr_lat by the decoder
//   regnum_t / lat_t   : register-number and latency field types
package hazard_pkg;

  localparam int NREG_DEF   = 32;
  localparam int AW_DEF     = 5;
  localparam int LATW_DEF   = 3;
  localparam int NRD_DEF    = 2;
  localparam int WB_LAT_DEF = 3;

  typedef logic [AW_DEF-1:0]   regnum_t;
  typedef logic [LATW_DEF-1:0] lat_t;

  localparam lat_t LAT_ALU  = 3'd1;
  localparam lat_t LAT_LOAD = 3'd2;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage <-> scoreboard bundle.
//   master : ID stage, drives the instruction fields and flush, sees the verdict
//   slave  : scoreboard, returns stall/issue (combinational) and busy/stall_cnt
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int LATW = LATW_DEF
);

  logic                   id_valid;
  logic [NRD-1:0][AW-1:0] rd_num;
  logic [NRD-1:0]         rd_used;
  logic                   wr_en;
  logic [AW-1:0]          wr_num;
  logic [LATW-1:0]        wr_lat;
  logic                   flush;
  logic                   stall;
  logic                   issue;
  logic                   busy;
  logic [31:0]            stall_cnt;

  modport master (
    output id_valid, rd_num, rd_used, wr_en, wr_num, wr_lat, flush,
    input  stall, issue, busy, stall_cnt
  );

  modport slave (
    input  id_valid, rd_num, rd_used, wr_en, wr_num, wr_lat, flush,
    output stall, issue, busy, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_pend_counter.sv
// pend_counter: one register's result-latency countdown.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load_en   : an instruction writing this register issues this cycle
//   load_lat  : its latency in cycles
//   pend      : current countdown; nonzero means the value is not yet readable
//   pend_nxt  : value the countdown takes at the next edge (ignoring rst)
// The issue cycle itself is the first latency cycle, so a latency L leaves
// L-1 visible in the cycle after issue: ALU (1) never blocks a consumer,
// a load (2) blocks exactly one.
module pend_counter
  import hazard_pkg::*;
#(
  parameter int LATW = LATW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [LATW-1:0] load_lat,
  output logic [LATW-1:0] pend,
  output logic [LATW-1:0] pend_nxt
);

  localparam logic [LATW-1:0] ZERO = {LATW{1'b0}};
  localparam logic [LATW-1:0] ONE  = {{(LATW-1){1'b0}}, 1'b1};

  logic [LATW-1:0] pend_r;
  logic [LATW-1:0] dec_s;
  logic [LATW-1:0] ld_dec_s;
  logic [LATW-1:0] nxt_s;

  function automatic logic [LATW-1:0] sat_dec(input logic [LATW-1:0] v);
    if (v != ZERO) begin
      sat_dec = v - ONE;
    end else begin
      sat_dec = ZERO;
    end
  endfunction

  // Next count: decrement, and on a new write keep the later of old and new.
  always_comb begin
    dec_s    = sat_dec(pend_r);
    ld_dec_s = sat_dec(load_lat);
    nxt_s    = dec_s;
    if (load_en && (ld_dec_s > dec_s)) begin
      nxt_s = ld_dec_s;
    end else begin
      nxt_s = dec_s;
    end
  end

  // Countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= ZERO;
    end else begin
      pend_r <= nxt_s;
    end
  end

  assign pend     = pend_r;
  assign pend_nxt = nxt_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW interlock for an in-order ID stage.
//   clk, rst     : clock, synchronous active-high reset
//   hs (slave)   : id_valid, rd_num/rd_used (NRD sources), wr_en/wr_num/wr_lat,
//                  flush in; stall, issue (combinational), busy, stall_cnt
//                  (registered) out
// stall/issue look only at the current countdowns and the ID fields, never at
// their own outputs, so there is no combinational loop through the pipeline.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int LATW   = LATW_DEF,
  parameter int FWD_EN = 1,
  parameter int WB_LAT = WB_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hs
);

  localparam logic [LATW-1:0] ZERO_LAT = {LATW{1'b0}};
  localparam logic [31:0]     CNT_MAX  = 32'hFFFF_FFFF;
  localparam logic [31:0]     CNT_ONE  = 32'h0000_0001;

  logic [LATW-1:0] pend_s     [NREG];
  logic [LATW-1:0] pend_nxt_s [NREG];
  logic [NRD-1:0]  hit_s;
  logic            stall_s;
  logic            issue_s;
  logic [LATW-1:0] load_lat_s;
  logic            busy_nxt_s;
  logic            busy_r;
  logic [31:0]     stall_cnt_r;

  // $0 is hardwired, so it can never be pending.
  assign pend_s[0]     = ZERO_LAT;
  assign pend_nxt_s[0] = ZERO_LAT;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    logic load_sel_s;
    assign load_sel_s = issue_s && hs.wr_en && (hs.wr_num == AW'(r));
    pend_counter #(.LATW(LATW)) u_pend (
      .clk      (clk),
      .rst      (rst),
      .load_en  (load_sel_s),
      .load_lat (load_lat_s),
      .pend     (pend_s[r]),
      .pend_nxt (pend_nxt_s[r])
    );
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    assign hit_s[p] = hs.rd_used[p] && (pend_s[hs.rd_num[p]] != ZERO_LAT);
  end

  // Latency source: decoder-supplied with forwarding, fixed writeback otherwise.
  always_comb begin
    load_lat_s = ZERO_LAT;
    if (FWD_EN != 0) begin
      load_lat_s = hs.wr_lat;
    end else begin
      load_lat_s = LATW'(WB_LAT);
    end
  end

  // Issue decision; flush squashes the instruction and masks the stall.
  always_comb begin
    stall_s = 1'b0;
    issue_s = 1'b0;
    if (hs.id_valid && !hs.flush) begin
      stall_s = |hit_s;
      issue_s = ~(|hit_s);
    end else begin
      stall_s = 1'b0;
      issue_s = 1'b0;
    end
  end

  // busy reflects the countdowns that will be live after this edge.
  always_comb begin
    busy_nxt_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      busy_nxt_s = busy_nxt_s | (pend_nxt_s[r] != ZERO_LAT);
    end
  end

  // busy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hs.stall     = stall_s;
  assign hs.issue     = issue_s;
  assign hs.busy      = busy_r;
  assign hs.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: two scoreboards (forwarding, and no-forward with WB_LAT=3) share one
// stimulus stream. The reference model tracks, per register, the absolute
// cycle at which its value becomes readable; a source stalls while the
// current cycle is earlier than that. Expectations are queued by the driver
// and checked by an independent monitor on the falling edge.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(5), .NRD(2), .LATW(3)) if_f ();
  hazard_scoreboard_if #(.AW(5), .NRD(2), .LATW(3)) if_n ();

  hazard_scoreboard #(.FWD_EN(1)) dut_f (.clk(clk), .rst(rst), .hs(if_f));
  hazard_scoreboard #(.FWD_EN(0), .WB_LAT(3)) dut_n (.clk(clk), .rst(rst), .hs(if_n));

  logic            b_v = 1'b0;
  logic [1:0][4:0] b_rn = '0;
  logic [1:0]      b_used = 2'b00;
  logic            b_we = 1'b0;
  logic [4:0]      b_wn = 5'd0;
  lat_t            b_wl = 3'd0;
  logic            b_fl = 1'b0;

  assign if_f.id_valid = b_v;    assign if_n.id_valid = b_v;
  assign if_f.rd_num   = b_rn;   assign if_n.rd_num   = b_rn;
  assign if_f.rd_used  = b_used; assign if_n.rd_used  = b_used;
  assign if_f.wr_en    = b_we;   assign if_n.wr_en    = b_we;
  assign if_f.wr_num   = b_wn;   assign if_n.wr_num   = b_wn;
  assign if_f.wr_lat   = b_wl;   assign if_n.wr_lat   = b_wl;
  assign if_f.flush    = b_fl;   assign if_n.flush    = b_fl;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  is;
    logic [1:0]  bz;
    logic [31:0] ct0;
    logic [31:0] ct1;
    int          sp_st;
    int          sp_is;
    int          sp_bz;
    int          sp_ct;
    int          sp_nfst;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  longint      rdy [2][32];
  longint      cyc = 0;
  logic [31:0] cnt [2];

  initial begin
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 32'd0;
      for (int r = 0; r < 32; r++) rdy[m][r] = 0;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle-time=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: checks the DUT outputs of the cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("f_stall", {31'd0, if_f.stall}, {31'd0, e.st[0]});
      cmp("f_issue", {31'd0, if_f.issue}, {31'd0, e.is[0]});
      cmp("f_busy",  {31'd0, if_f.busy},  {31'd0, e.bz[0]});
      cmp("f_cnt",   if_f.stall_cnt,      e.ct0);
      cmp("n_stall", {31'd0, if_n.stall}, {31'd0, e.st[1]});
      cmp("n_issue", {31'd0, if_n.issue}, {31'd0, e.is[1]});
      cmp("n_busy",  {31'd0, if_n.busy},  {31'd0, e.bz[1]});
      cmp("n_cnt",   if_n.stall_cnt,      e.ct1);
      if (e.sp_st >= 0)   cmp("spec_stall",    {31'd0, if_f.stall}, 32'(e.sp_st));
      if (e.sp_is >= 0)   cmp("spec_issue",    {31'd0, if_f.issue}, 32'(e.sp_is));
      if (e.sp_bz >= 0)   cmp("spec_busy",     {31'd0, if_f.busy},  32'(e.sp_bz));
      if (e.sp_ct >= 0)   cmp("spec_cnt",      if_f.stall_cnt,      32'(e.sp_ct));
      if (e.sp_nfst >= 0) cmp("spec_nf_stall", {31'd0, if_n.stall}, 32'(e.sp_nfst));
    end
  end

  // One ID cycle: apply inputs, queue expectations, advance the model, wait an edge.
  task automatic drive(input logic v, input int r0, input int r1, input logic [1:0] used,
                       input logic we, input int wn, input int wl, input logic fl,
                       input logic r, input int s_st = -1, input int s_is = -1,
                       input int s_bz = -1, input int s_ct = -1, input int s_nfst = -1);
    exp_t   e;
    longint lat;
    b_v = v; b_rn[0] = 5'(r0); b_rn[1] = 5'(r1); b_used = used;
    b_we = we; b_wn = 5'(wn); b_wl = 3'(wl); b_fl = fl; rst = r;
    for (int m = 0; m < 2; m++) begin
      logic haz;
      logic any;
      haz = (used[0] && r0 != 0 && rdy[m][r0] > cyc) ||
            (used[1] && r1 != 0 && rdy[m][r1] > cyc);
      e.st[m] = v && !fl && haz;
      e.is[m] = v && !fl && !haz;
      any = 1'b0;
      for (int k = 1; k < 32; k++) if (rdy[m][k] > cyc) any = 1'b1;
      e.bz[m] = any;
    end
    e.ct0 = cnt[0]; e.ct1 = cnt[1];
    e.sp_st = s_st; e.sp_is = s_is; e.sp_bz = s_bz; e.sp_ct = s_ct; e.sp_nfst = s_nfst;
    q.push_back(e);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        cnt[m] = 32'd0;
        for (int k = 0; k < 32; k++) rdy[m][k] = 0;
      end else begin
        if (e.st[m] && cnt[m] != 32'hFFFF_FFFF) cnt[m] = cnt[m] + 32'd1;
        if (e.is[m] && we && wn != 0) begin
          lat = (m == 0) ? longint'(wl) : 64'd3;
          if (cyc + lat > rdy[m][wn]) rdy[m][wn] = cyc + lat;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int s_bz = -1, input int s_ct = -1);
    drive(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, -1, -1, s_bz, s_ct);
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    idle(0, 0);

    // Load-use: one bubble, then issue; one stall counted.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 8, int'(LAT_LOAD), 1'b0, 1'b0, 0, 1);
    drive(1'b1, 8, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 1, 0, 1);
    drive(1'b1, 8, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1);
    idle(0, 1);

    // ALU back-to-back: no stall.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 5, int'(LAT_ALU), 1'b0, 1'b0, 0, 1);
    drive(1'b1, 0, 5, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 0);

    // $0 never pending; unused source ignored.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 0, 3, 1'b0, 1'b0, 0, 1);
    drive(1'b1, 0, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 0);
    drive(1'b1, 0, 0, 2'b00, 1'b1, 6, 3, 1'b0, 1'b0, 0, 1);
    drive(1'b1, 6, 6, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 1);

    // No-forward WB_LAT=3: two stall cycles on that instance.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 9, 1, 1'b0, 1'b0);
    drive(1'b1, 9, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, -1, -1, 1);
    drive(1'b1, 9, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, -1, -1, 1);
    drive(1'b1, 9, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, -1, -1, 0);

    // Flush masks the stall; the countdown keeps its schedule.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 4, 3, 1'b0, 1'b0, 0, 1);
    drive(1'b1, 4, 0, 2'b01, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1);
    drive(1'b1, 4, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 1, 0, 1);
    drive(1'b1, 4, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 0);
    idle(0, 1);

    // Reset mid-countdown discards state.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 7, 3, 1'b0, 1'b0, 0, 1);
    drive(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1, 0, 0, 1);
    drive(1'b1, 7, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 0, 0);

    // Latency 0 never pends; self-dependence checks only the pre-issue value.
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 10, 0, 1'b0, 1'b0, 0, 1);
    drive(1'b1, 10, 0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 0);
    drive(1'b1, 12, 0, 2'b01, 1'b1, 12, 3, 1'b0, 1'b0, 0, 1);
    drive(1'b1, 12, 0, 2'b01, 1'b1, 12, 3, 1'b0, 1'b0, 1, 0, 1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    idle();
    idle();
    cmp("queue_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
